// File: rtl/preload_pkg.sv
// Shared definitions for the regfile preloader.
// Contents:
//   state_t        FSM state encoding (CKSUM is only reachable with PRELOAD_CKSUM_EN)
//   DEF_SYNC_BYTE  default frame start marker
//   DEF_END_BYTE   default session terminator
//   DATA_BYTES     payload bytes per frame (little-endian word)
//   IDX_W          width of the register index field
package preload_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_IDX,
    ST_DATA,
    ST_CKSUM,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam logic [7:0] DEF_END_BYTE  = 8'h5A;
  localparam int         DATA_BYTES    = 4;
  localparam int         IDX_W         = 5;

endpackage

// File: rtl/preload_word_assembler.sv
// Little-endian word assembler for the regfile preloader.
// Bytes shifted in enter at the top and move down, so after DATA_BYTES
// shifts the first byte sits in bits 7:0 and the last in the top byte.
// A running XOR covers every shifted or folded byte since the last clear,
// which lets the frame checksum include the index byte.
// Ports:
//   clock, reset   system clock, synchronous active-high reset (counter only)
//   clear          restart assembly (count and running XOR to zero)
//   shift          accept byte_in as the next payload byte
//   fold           XOR byte_in into the checksum without storing it
//   byte_in        incoming byte
//   word           assembled word
//   full           all DATA_BYTES payload bytes received
//   last           next shift completes the word
//   xor_acc        running XOR of folded and shifted bytes
module preload_word_assembler
  import preload_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    shift,
  input  logic                    fold,
  input  logic [7:0]              byte_in,
  output logic [8*DATA_BYTES-1:0] word,
  output logic                    full,
  output logic                    last,
  output logic [7:0]              xor_acc
);

  logic [2:0] count;

  assign full = (count == 3'(DATA_BYTES));
  assign last = (count == 3'(DATA_BYTES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (shift && !full) begin
      count <= count + 3'd1;
    end
  end

  // Payload storage carries no reset; it is always refilled before use.
  always_ff @(posedge clock) begin
    if (shift && !full) begin
      word <= {byte_in, word[8*DATA_BYTES-1:8]};
    end
    if (clear) begin
      xor_acc <= '0;
    end else if (shift || fold) begin
      xor_acc <= xor_acc ^ byte_in;
    end
  end

endmodule

// File: rtl/regfile_preloader.sv
// Regfile preloader: sits between the processor's regfile write port and
// the regfile. Outside a load session processor writes pass straight
// through. A session (opened by start) holds the processor in reset and
// writes one register per received byte-stream frame:
//   SYNC_BYTE, index (0..31), 4 data bytes little-endian [, checksum]
// END_BYTE in place of a frame start closes the session cleanly.
// Optional feature macro: PRELOAD_CKSUM_EN -- adds a 7th frame byte equal
// to the XOR of the index byte and the 4 data bytes; a mismatch is an error.
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   start               one-cycle pulse opening a session (IDLE/DONE/ERR only)
//   in_valid/in_data    byte stream; in_ready accepts a byte
//   cpu_we/rd/wdata     processor regfile write port
//   rf_we/rd/wdata      regfile write port
//   cpu_reset_hold      OR'ed into the processor reset
//   busy                session active (state not IDLE/DONE)
//   done, err           sticky session outcome flags
//   load_count          frames written this session (r0 frames included)
module regfile_preloader
  import preload_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE  = DEF_SYNC_BYTE,
  parameter logic [7:0] END_BYTE   = DEF_END_BYTE,
  parameter int         MAX_FRAMES = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        cpu_we,
  input  logic [4:0]  cpu_rd,
  input  logic [31:0] cpu_wdata,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata,
  output logic        cpu_reset_hold,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [5:0]  load_count
);

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic                    wr_en;
  logic                    accept;
  logic                    asm_clear;
  logic                    asm_shift;
  logic                    asm_fold;
  logic [8*DATA_BYTES-1:0] asm_word;
  logic                    asm_full;
  logic                    asm_last;
  logic [7:0]              asm_xor;
  logic                    passthrough;

  assign accept    = in_valid && in_ready;
  assign asm_clear = accept && (state == ST_SYNC) && (in_data == SYNC_BYTE);
  assign asm_fold  = accept && (state == ST_IDX);
  assign asm_shift = accept && (state == ST_DATA);

  preload_word_assembler u_asm (
    .clock   (clock),
    .reset   (reset),
    .clear   (asm_clear),
    .shift   (asm_shift),
    .fold    (asm_fold),
    .byte_in (in_data),
    .word    (asm_word),
    .full    (asm_full),
    .last    (asm_last),
    .xor_acc (asm_xor)
  );

`ifndef PRELOAD_CKSUM_EN
  logic unused_cksum;
  assign unused_cksum = ^asm_xor;
`endif

  // Index is data: loaded on every index handshake, never reset.
  always_ff @(posedge clock) begin
    if (asm_fold) begin
      idx <= in_data[IDX_W-1:0];
    end
  end

  // Session FSM; all control outputs are registered and updated on the
  // transition that enters the state they belong to.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      in_ready       <= 1'b0;
      cpu_reset_hold <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      load_count     <= '0;
      wr_en          <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state          <= ST_SYNC;
            in_ready       <= 1'b1;
            cpu_reset_hold <= 1'b1;
            busy           <= 1'b1;
            done           <= 1'b0;
            err            <= 1'b0;
            load_count     <= '0;
          end
        end
        ST_SYNC: begin
          if (accept) begin
            if (in_data == SYNC_BYTE) begin
              if (load_count == 6'(MAX_FRAMES)) begin
                state <= ST_ERR;
                err   <= 1'b1;
              end else begin
                state <= ST_IDX;
              end
            end else if (in_data == END_BYTE) begin
              state          <= ST_DONE;
              in_ready       <= 1'b0;
              cpu_reset_hold <= 1'b0;
              busy           <= 1'b0;
              done           <= 1'b1;
            end
          end
        end
        ST_IDX: begin
          if (accept) begin
            if (in_data[7:IDX_W] != '0) begin
              state <= ST_ERR;
              err   <= 1'b1;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (accept && asm_last) begin
`ifdef PRELOAD_CKSUM_EN
            state    <= ST_CKSUM;
`else
            state    <= ST_WRITE;
            in_ready <= 1'b0;
            wr_en    <= (idx != '0);
`endif
          end
        end
`ifdef PRELOAD_CKSUM_EN
        ST_CKSUM: begin
          if (accept) begin
            if (in_data == asm_xor) begin
              state    <= ST_WRITE;
              in_ready <= 1'b0;
              wr_en    <= (idx != '0);
            end else begin
              state <= ST_ERR;
              err   <= 1'b1;
            end
          end
        end
`endif
        ST_WRITE: begin
          state      <= ST_SYNC;
          in_ready   <= 1'b1;
          load_count <= load_count + 6'd1;
        end
        default: begin
          state          <= ST_IDLE;
          in_ready       <= 1'b0;
          cpu_reset_hold <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

  assign passthrough = (state == ST_IDLE) || (state == ST_DONE);

  // Preloader writes are suppressed on a reset cycle so an interrupted
  // session never leaves a partial register behind.
  always_comb begin
    if (passthrough) begin
      rf_we    = cpu_we;
      rf_rd    = cpu_rd;
      rf_wdata = cpu_wdata;
    end else begin
      rf_we    = wr_en && asm_full && !reset;
      rf_rd    = idx;
      rf_wdata = asm_word;
    end
  end

endmodule

// File: tb/tb_regfile_preloader.sv
module tb_regfile_preloader;

  localparam logic [7:0] SYNC_B = 8'hA5;
  localparam logic [7:0] END_B  = 8'h5A;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        cpu_we = 1'b0;
  logic [4:0]  cpu_rd = 5'd0;
  logic [31:0] cpu_wdata = 32'd0;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        cpu_reset_hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [5:0]  load_count;

  int tests_run = 0;
  int tests_failed = 0;
  int wr_cnt = 0;
  int r0_writes = 0;
  logic [31:0] regs [32];

  regfile_preloader #(.MAX_FRAMES(2)) dut (
    .clock(clock), .reset(reset), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cpu_we(cpu_we), .cpu_rd(cpu_rd), .cpu_wdata(cpu_wdata),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .cpu_reset_hold(cpu_reset_hold), .busy(busy), .done(done),
    .err(err), .load_count(load_count)
  );

  always #5 clock = ~clock;

  // Shadow regfile: records every write the regfile would see.
  always @(negedge clock) begin
    if (rf_we) begin
      wr_cnt = wr_cnt + 1;
      if (rf_rd == 5'd0) r0_writes = r0_writes + 1;
      regs[rf_rd] = rf_wdata;
    end
  end

  task automatic do_reset();
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
    @(negedge clock); reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
  endtask

  // Presents a byte and returns 1 time unit after the handshake edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clock);
    in_valid = 1'b1; in_data = b;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    tests_run++;
    if (n >= 50) begin
      tests_failed++;
      $display("FAIL send_byte_timeout: byte %h not accepted, in_ready=%b want 1", b, in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clock); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] ix, input logic [31:0] w);
    send_byte(SYNC_B);
    send_byte(ix);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
`ifdef PRELOAD_CKSUM_EN
    send_byte(ix ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24]);
`endif
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    tests_run++; if (cpu_reset_hold !== 1'b0) begin tests_failed++; $display("FAIL reset_hold: got %b want 0", cpu_reset_hold); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", done); end
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b want 0", err); end
    tests_run++; if (load_count !== 6'd0) begin tests_failed++; $display("FAIL reset_load_count: got %0d want 0", load_count); end
    tests_run++; if (rf_we !== 1'b0) begin tests_failed++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
  endtask

  task automatic test_passthrough();
    @(negedge clock);
    cpu_we = 1'b1; cpu_rd = 5'd7; cpu_wdata = 32'd99;
    #1;
    tests_run++; if (rf_we !== 1'b1) begin tests_failed++; $display("FAIL pass_we: got %b want 1", rf_we); end
    tests_run++; if (rf_rd !== 5'd7) begin tests_failed++; $display("FAIL pass_rd: got %0d want 7", rf_rd); end
    tests_run++; if (rf_wdata !== 32'd99) begin tests_failed++; $display("FAIL pass_wdata: got %0d want 99", rf_wdata); end
    tests_run++; if (cpu_reset_hold !== 1'b0) begin tests_failed++; $display("FAIL pass_hold: got %b want 0", cpu_reset_hold); end
    cpu_we = 1'b0; cpu_rd = 5'd0; cpu_wdata = 32'd0;
  endtask

  task automatic test_single_load();
    pulse_start();
    wr_cnt = 0;
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy: got %b want 1", busy); end
    tests_run++; if (cpu_reset_hold !== 1'b1) begin tests_failed++; $display("FAIL single_hold: got %b want 1", cpu_reset_hold); end
    // Processor writes during the session must be discarded.
    cpu_we = 1'b1; cpu_rd = 5'd9; cpu_wdata = 32'hDEAD;
    send_frame(8'h03, 32'h12345678);
    @(negedge clock);
    tests_run++; if (rf_we !== 1'b1) begin tests_failed++; $display("FAIL single_latency_we: got %b want 1", rf_we); end
    tests_run++; if (rf_rd !== 5'd3) begin tests_failed++; $display("FAIL single_rd: got %0d want 3", rf_rd); end
    tests_run++; if (rf_wdata !== 32'h12345678) begin tests_failed++; $display("FAIL single_wdata: got %h want 12345678", rf_wdata); end
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL single_write_ready: got %b want 0", in_ready); end
    cpu_we = 1'b0; cpu_rd = 5'd0; cpu_wdata = 32'd0;
    send_byte(END_B);
    @(negedge clock);
    tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL single_done: got %b want 1", done); end
    tests_run++; if (cpu_reset_hold !== 1'b0) begin tests_failed++; $display("FAIL single_hold_release: got %b want 0", cpu_reset_hold); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_busy_end: got %b want 0", busy); end
    tests_run++; if (load_count !== 6'd1) begin tests_failed++; $display("FAIL single_load_count: got %0d want 1", load_count); end
    tests_run++; if (wr_cnt !== 1) begin tests_failed++; $display("FAIL single_wr_cnt: got %0d want 1", wr_cnt); end
  endtask

  task automatic test_r0_garbage();
    pulse_start();
    wr_cnt = 0; r0_writes = 0;
    send_byte(8'h11);
    send_byte(8'h22);
    send_frame(8'h00, 32'h00000001);
    send_frame(8'h1F, 32'hFFFFFFFF);
    send_byte(END_B);
    @(negedge clock);
    tests_run++; if (r0_writes !== 0) begin tests_failed++; $display("FAIL r0_written: got %0d want 0", r0_writes); end
    tests_run++; if (wr_cnt !== 1) begin tests_failed++; $display("FAIL r0_wr_cnt: got %0d want 1", wr_cnt); end
    tests_run++; if (regs[31] !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL r31_value: got %h want ffffffff", regs[31]); end
    tests_run++; if (load_count !== 6'd2) begin tests_failed++; $display("FAIL r0_load_count: got %0d want 2", load_count); end
    tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL r0_done: got %b want 1", done); end
  endtask

  task automatic test_bad_index();
    pulse_start();
    wr_cnt = 0;
    send_byte(SYNC_B);
    send_byte(8'h20);
    send_byte(8'h01);
    send_byte(8'h02);
    @(negedge clock);
    tests_run++; if (err !== 1'b1) begin tests_failed++; $display("FAIL badidx_err: got %b want 1", err); end
    tests_run++; if (cpu_reset_hold !== 1'b1) begin tests_failed++; $display("FAIL badidx_hold: got %b want 1", cpu_reset_hold); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL badidx_drain: got %b want 1", in_ready); end
    tests_run++; if (wr_cnt !== 0) begin tests_failed++; $display("FAIL badidx_wr_cnt: got %0d want 0", wr_cnt); end
    pulse_start();
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL restart_err_clear: got %b want 0", err); end
    send_frame(8'h01, 32'h00000005);
    send_byte(END_B);
    @(negedge clock);
    tests_run++; if (regs[1] !== 32'd5) begin tests_failed++; $display("FAIL restart_r1: got %h want 5", regs[1]); end
    tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL restart_done: got %b want 1", done); end
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL restart_err: got %b want 0", err); end
    tests_run++; if (wr_cnt !== 1) begin tests_failed++; $display("FAIL restart_wr_cnt: got %0d want 1", wr_cnt); end
  endtask

  task automatic test_stall_reset();
    pulse_start();
    wr_cnt = 0;
    regs[4] = 32'h0;
    send_byte(SYNC_B);
    send_byte(8'h04);
    send_byte(8'hEF);
    send_byte(8'hBE);
    repeat (10) @(negedge clock);
    tests_run++; if (wr_cnt !== 0) begin tests_failed++; $display("FAIL stall_wr_cnt: got %0d want 0", wr_cnt); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL stall_busy: got %b want 1", busy); end
    do_reset();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL stall_reset_busy: got %b want 0", busy); end
    tests_run++; if (cpu_reset_hold !== 1'b0) begin tests_failed++; $display("FAIL stall_reset_hold: got %b want 0", cpu_reset_hold); end
    tests_run++; if (regs[4] !== 32'h0) begin tests_failed++; $display("FAIL stall_r4: got %h want 0", regs[4]); end
    // Reset landing on the write cycle must suppress the write.
    pulse_start();
    wr_cnt = 0;
    send_frame(8'h05, 32'hCAFEF00D);
    reset = 1'b1;
    @(negedge clock);
    tests_run++; if (rf_we !== 1'b0) begin tests_failed++; $display("FAIL reset_on_write_we: got %b want 0", rf_we); end
    @(negedge clock); reset = 1'b0;
    @(negedge clock);
    tests_run++; if (wr_cnt !== 0) begin tests_failed++; $display("FAIL reset_on_write_cnt: got %0d want 0", wr_cnt); end
    tests_run++; if (load_count !== 6'd0) begin tests_failed++; $display("FAIL reset_on_write_lc: got %0d want 0", load_count); end
  endtask

  task automatic test_frame_limit();
    pulse_start();
    wr_cnt = 0;
    send_frame(8'h01, 32'h00000011);
    send_frame(8'h02, 32'h00000022);
    send_byte(SYNC_B);
    @(negedge clock);
    tests_run++; if (err !== 1'b1) begin tests_failed++; $display("FAIL limit_err: got %b want 1", err); end
    tests_run++; if (load_count !== 6'd2) begin tests_failed++; $display("FAIL limit_load_count: got %0d want 2", load_count); end
    tests_run++; if (wr_cnt !== 2) begin tests_failed++; $display("FAIL limit_wr_cnt: got %0d want 2", wr_cnt); end
    tests_run++; if (regs[2] !== 32'h22) begin tests_failed++; $display("FAIL limit_r2: got %h want 22", regs[2]); end
  endtask

`ifdef PRELOAD_CKSUM_EN
  task automatic test_checksum();
    logic [7:0] bad_seq [7];
    pulse_start();
    wr_cnt = 0;
    bad_seq = '{8'hA5, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
    for (int i = 0; i < 7; i++) send_byte(bad_seq[i]);
    @(negedge clock);
    tests_run++; if (err !== 1'b1) begin tests_failed++; $display("FAIL cksum_bad_err: got %b want 1", err); end
    tests_run++; if (wr_cnt !== 0) begin tests_failed++; $display("FAIL cksum_bad_wr: got %0d want 0", wr_cnt); end
    tests_run++; if (load_count !== 6'd0) begin tests_failed++; $display("FAIL cksum_bad_lc: got %0d want 0", load_count); end
    pulse_start();
    bad_seq[6] = 8'h03;
    for (int i = 0; i < 7; i++) send_byte(bad_seq[i]);
    send_byte(END_B);
    @(negedge clock);
    tests_run++; if (regs[2] !== 32'd1) begin tests_failed++; $display("FAIL cksum_good_r2: got %h want 1", regs[2]); end
    tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL cksum_good_done: got %b want 1", done); end
  endtask
`endif

  initial begin
    test_reset();
    test_passthrough();
    test_single_load();
    test_r0_garbage();
    test_bad_index();
    test_stall_reset();
    test_frame_limit();
`ifdef PRELOAD_CKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
